// File: rtl/rxaclbuf_pingpong_ctrl.sv
// Ping-pong controller for two RX ACL payload SRAM banks: the link controller
// fills one bank while the baseband state machine drains the other.
module rxaclbuf_pingpong_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk_6M,
  input  logic          rst,
  input  logic          lnctrl_start,
  input  logic          lnctrl_we,
  input  logic [DW-1:0] lnctrl_din,
  input  logic          lnctrl_end,
  input  logic          lnctrl_abort,
  output logic          lnctrl_busy,
  output logic          lnctrl_ovf,
  input  logic          bsm_cs,
  input  logic [AW-1:0] bsm_addr,
  input  logic          bsm_read_endp,
  output logic          bsm_avail,
  output logic [AW:0]   bsm_len,
  output logic [DW-1:0] bsm_dout,
  output logic [AW-1:0] bank0_a,
  output logic [DW-1:0] bank0_din,
  output logic          bank0_we,
  output logic          bank0_cs,
  input  logic [DW-1:0] bank0_dout,
  output logic [AW-1:0] bank1_a,
  output logic [DW-1:0] bank1_din,
  output logic          bank1_we,
  output logic          bank1_cs,
  input  logic [DW-1:0] bank1_dout
);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILL = 2'd1, B_FULL = 2'd2} bank_st_e;
  typedef enum logic {W_IDLE = 1'b0, W_WRITE = 1'b1} wr_st_e;

  wr_st_e        wr_st_q, wr_st_d;
  bank_st_e      bank_q [2];
  bank_st_e      bank_d [2];
  logic [AW:0]   len_q  [2];
  logic [AW:0]   len_d  [2];
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          dsel_q, dsel_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   wcnt;
  logic          avail;

  logic [1:0]          b_cs, b_we;
  logic [1:0][AW-1:0]  b_a;
  logic [1:0][DW-1:0]  b_din;

  always_comb begin
    wr_st_d = wr_st_q;
    bank_d  = bank_q;
    len_d   = len_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    dsel_d  = dsel_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    wcnt    = wptr_q;
    b_cs    = '0;
    b_we    = '0;
    b_a     = '0;
    b_din   = '0;
    avail   = (bank_q[rb_q] == B_FULL);

    case (wr_st_q)
      W_IDLE: begin
        if (lnctrl_start) begin
          if (bank_q[wb_q] == B_EMPTY) begin
            wr_st_d      = W_WRITE;
            bank_d[wb_q] = B_FILL;
            wptr_d       = '0;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      W_WRITE: begin
        if (lnctrl_we) begin
          if (!wptr_q[AW]) begin
            b_cs[wb_q]  = 1'b1;
            b_we[wb_q]  = 1'b1;
            b_a[wb_q]   = wptr_q[AW-1:0];
            b_din[wb_q] = lnctrl_din;
            wcnt        = wptr_q + (AW+1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        wptr_d = wcnt;
        // abort wins over restart, restart over commit
        if (lnctrl_abort) begin
          bank_d[wb_q] = B_EMPTY;
          wr_st_d      = W_IDLE;
        end else if (lnctrl_start) begin
          wptr_d = '0;
        end else if (lnctrl_end) begin
          bank_d[wb_q] = B_FULL;
          len_d[wb_q]  = wcnt;
          wb_d         = ~wb_q;
          wr_st_d      = W_IDLE;
        end
      end
      default: wr_st_d = W_IDLE;
    endcase

    // Reader only touches a FULL bank; the writer only an EMPTY/FILL one.
    if (bsm_cs && avail) begin
      b_cs[rb_q] = 1'b1;
      b_a[rb_q]  = bsm_addr;
      dsel_d     = rb_q;
    end
    if (bsm_read_endp && avail) begin
      bank_d[rb_q] = B_EMPTY;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      wr_st_q <= W_IDLE;
      bank_q  <= '{default: B_EMPTY};
      len_q   <= '{default: '0};
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      dsel_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
    end else begin
      wr_st_q <= wr_st_d;
      bank_q  <= bank_d;
      len_q   <= len_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      dsel_q  <= dsel_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
    end
  end

  assign lnctrl_busy = (bank_q[wb_q] != B_EMPTY);
  assign lnctrl_ovf  = ovf_q;
  assign bsm_avail   = avail;
  assign bsm_len     = len_q[rb_q];
  assign bsm_dout    = dsel_q ? bank1_dout : bank0_dout;

  assign bank0_cs  = b_cs[0];
  assign bank0_we  = b_we[0];
  assign bank0_a   = b_a[0];
  assign bank0_din = b_din[0];
  assign bank1_cs  = b_cs[1];
  assign bank1_we  = b_we[1];
  assign bank1_a   = b_a[1];
  assign bank1_din = b_din[1];

endmodule

// File: tb/tb_rxaclbuf_pingpong_ctrl.sv
// Directed bench for rxaclbuf_pingpong_ctrl with behavioural SRAM banks and a
// read-data scoreboard.
module tb_rxaclbuf_pingpong_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk_6M = 1'b0;
  logic          rst;
  logic          lnctrl_start, lnctrl_we, lnctrl_end, lnctrl_abort;
  logic [DW-1:0] lnctrl_din;
  logic          lnctrl_busy, lnctrl_ovf;
  logic          bsm_cs, bsm_read_endp, bsm_avail;
  logic [AW-1:0] bsm_addr;
  logic [AW:0]   bsm_len;
  logic [DW-1:0] bsm_dout;
  logic [AW-1:0] bank0_a, bank1_a;
  logic [DW-1:0] bank0_din, bank1_din, bank0_dout, bank1_dout;
  logic          bank0_we, bank1_we, bank0_cs, bank1_cs;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  rxaclbuf_pingpong_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk_6M(clk_6M), .rst(rst),
    .lnctrl_start(lnctrl_start), .lnctrl_we(lnctrl_we), .lnctrl_din(lnctrl_din),
    .lnctrl_end(lnctrl_end), .lnctrl_abort(lnctrl_abort),
    .lnctrl_busy(lnctrl_busy), .lnctrl_ovf(lnctrl_ovf),
    .bsm_cs(bsm_cs), .bsm_addr(bsm_addr), .bsm_read_endp(bsm_read_endp),
    .bsm_avail(bsm_avail), .bsm_len(bsm_len), .bsm_dout(bsm_dout),
    .bank0_a(bank0_a), .bank0_din(bank0_din), .bank0_we(bank0_we),
    .bank0_cs(bank0_cs), .bank0_dout(bank0_dout),
    .bank1_a(bank1_a), .bank1_din(bank1_din), .bank1_we(bank1_we),
    .bank1_cs(bank1_cs), .bank1_dout(bank1_dout)
  );

  always #5 clk_6M = ~clk_6M;

  always @(posedge clk_6M) begin
    if (bank0_cs) begin
      if (bank0_we) mem0[bank0_a] <= bank0_din;
      else          bank0_dout    <= mem0[bank0_a];
    end
    if (bank1_cs) begin
      if (bank1_we) mem1[bank1_a] <= bank1_din;
      else          bank1_dout    <= mem1[bank1_a];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    lnctrl_start = 0; lnctrl_we = 0; lnctrl_end = 0; lnctrl_abort = 0;
    bsm_cs = 0; bsm_read_endp = 0;
  endtask

  task automatic clk1();
    @(posedge clk_6M); #1; clr();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    lnctrl_we = 1; lnctrl_din = d; clk1();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bsm_cs = 1; bsm_addr = a; sb.push_back(exp); clk1();
    chk("bsm_dout", bsm_dout, sb.pop_front());
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, lnctrl_busy, 0);
    chk({tag, "_ovf"}, lnctrl_ovf, 0);
    chk({tag, "_avail"}, bsm_avail, 0);
    chk({tag, "_len"}, bsm_len, 0);
    chk({tag, "_strobes"}, {bank0_cs, bank0_we, bank1_cs, bank1_we}, 0);
    chk({tag, "_addr_din"}, {bank0_a, bank1_a, bank0_din, bank1_din}, 0);
  endtask

  initial begin
    clr(); rst = 1; lnctrl_din = '0; bsm_addr = '0;
    clk1(); clk1();
    chk_idle_outputs("reset");
    rst = 0; clk1();

    // single payload into bank0
    lnctrl_start = 1; clk1();
    chk("busy_fill", lnctrl_busy, 1);
    for (int i = 0; i < 5; i++) wr(32'h11 + 32'(i));
    lnctrl_end = 1; clk1();
    chk("avail_b0", bsm_avail, 1);
    chk("len_b0", bsm_len, 5);
    chk("busy_wb1", lnctrl_busy, 0);
    rd(2, 32'h13);
    rd(0, 32'h11);

    // fill bank1, then a third payload must be dropped
    lnctrl_start = 1; clk1();
    for (int i = 0; i < 3; i++) wr(32'h21 + 32'(i));
    lnctrl_end = 1; clk1();
    chk("busy_both_full", lnctrl_busy, 1);
    chk("ovf_before_drop", lnctrl_ovf, 0);
    lnctrl_start = 1; settle();
    chk("drop_start_no_we", {bank0_we, bank1_we}, 0);
    clk1();
    chk("ovf_after_drop", lnctrl_ovf, 1);
    lnctrl_we = 1; lnctrl_din = 32'h99; settle();
    chk("drop_word_no_we", {bank0_we, bank1_we}, 0);
    clk1();
    bsm_read_endp = 1; clk1();
    chk("avail_b1", bsm_avail, 1);
    chk("len_b1", bsm_len, 3);
    chk("busy_after_rel", lnctrl_busy, 0);
    rd(1, 32'h22);
    lnctrl_start = 1; clk1();
    chk("busy_refill_b0", lnctrl_busy, 1);
    lnctrl_we = 1; lnctrl_din = 32'h31; settle();
    chk("wr_b0_strobes", {bank0_cs, bank0_we, bank0_a, bank0_din, bank1_cs},
        {1'b1, 1'b1, 4'd0, 32'h31, 1'b0});
    clk1();
    lnctrl_end = 1; clk1();
    bsm_read_endp = 1; clk1();
    chk("len_b0_again", bsm_len, 1);
    rd(0, 32'h31);

    // write bank1 while reading bank0, then commit/release in one cycle
    lnctrl_start = 1; clk1();
    wr(32'h41);
    lnctrl_we = 1; lnctrl_din = 32'h42; bsm_cs = 1; bsm_addr = 0; settle();
    chk("concurrent_strobes", {bank0_cs, bank0_we, bank1_cs, bank1_we, bank1_a},
        {1'b1, 1'b0, 1'b1, 1'b1, 4'd1});
    sb.push_back(32'h31); clk1();
    chk("bsm_dout_concurrent", bsm_dout, sb.pop_front());
    lnctrl_end = 1; bsm_read_endp = 1; clk1();
    chk("same_cycle_avail", bsm_avail, 1);
    chk("same_cycle_len", bsm_len, 2);
    chk("same_cycle_busy", lnctrl_busy, 0);
    rd(1, 32'h42);

    // abort and ignored reader/writer pulses
    bsm_read_endp = 1; clk1();
    chk("avail_none", bsm_avail, 0);
    bsm_cs = 1; bsm_addr = 3; settle();
    chk("cs_no_avail", {bank0_cs, bank1_cs}, 0);
    clk1();
    lnctrl_end = 1; clk1();
    chk("end_in_idle", bsm_avail, 0);
    lnctrl_start = 1; clk1();
    for (int i = 0; i < 3; i++) wr(32'h51 + 32'(i));
    lnctrl_abort = 1; lnctrl_end = 1; clk1();
    chk("abort_busy", lnctrl_busy, 0);
    chk("abort_avail", bsm_avail, 0);
    lnctrl_start = 1; clk1();
    lnctrl_we = 1; lnctrl_din = 32'h61; settle();
    chk("post_abort_addr0", {bank0_we, bank0_a}, {1'b1, 4'd0});
    clk1();
    lnctrl_end = 1; clk1();
    chk("post_abort_len", {bsm_avail, bsm_len}, {1'b1, 5'd1});
    rd(0, 32'h61);

    // overflow of a bank
    rst = 1; clk1(); rst = 0;
    chk("ovf_cleared", lnctrl_ovf, 0);
    lnctrl_start = 1; clk1();
    for (int i = 0; i < 16; i++) wr(32'h100 + 32'(i));
    lnctrl_we = 1; lnctrl_din = 32'h110; settle();
    chk("word17_no_we", {bank0_we, bank1_we}, 0);
    clk1();
    lnctrl_end = 1; clk1();
    chk("full_len", bsm_len, 16);
    chk("full_ovf", lnctrl_ovf, 1);
    rd(15, 32'h10F);
    rd(0, 32'h100);

    // reset during a write into bank1
    lnctrl_start = 1; clk1();
    wr(32'h81); wr(32'h82);
    rst = 1; clk1();
    chk_idle_outputs("mid_write_rst");
    rst = 0;
    lnctrl_start = 1; clk1();
    wr(32'h71);
    lnctrl_end = 1; clk1();
    chk("after_rst_len", {bsm_avail, bsm_len}, {1'b1, 5'd1});
    rd(0, 32'h71);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
